// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operation encodings and the per-stage
// control flags carried alongside pipe_adder's payload.
package alu_pkg;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // carry: carry out of the segment just computed (carry-in for the next one)
    // cMsb : carry into the segment's top bit, used for signed overflow
    typedef struct packed {
        logic valid;
        logic carry;
        logic cMsb;
    } stageFlagsT;

endpackage

// File: rtl/mFulladder.sv
// Single-bit full adder cell, the ripple element of pipe_adder_seg.
module mFulladder (
    input  logic iA,
    input  logic iB,
    input  logic iC,
    output logic oSum,
    output logic oCarryout
);

    assign oSum      = iA ^ iB ^ iC;
    assign oCarryout = (iA & iB) | (iC & (iA ^ iB));

endmodule

// File: rtl/pipe_adder_seg.sv
// SEG-bit combinational ripple-carry segment built from mFulladder cells.
module pipe_adder_seg #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] iA,
    input  logic [SEG-1:0] iB,
    input  logic           iC,
    output logic [SEG-1:0] oSum,
    output logic           oCarryout,
    output logic           oC_msb
);

    logic [SEG:0] carry;

    assign carry[0] = iC;

    for (genvar i = 0; i < SEG; i++) begin : gBit
        mFulladder uFa (
            .iA        (iA[i]),
            .iB        (iB[i]),
            .iC        (carry[i]),
            .oSum      (oSum[i]),
            .oCarryout (carry[i+1])
        );
    end

    assign oCarryout = carry[SEG];
    assign oC_msb    = carry[SEG-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined ripple-carry add/subtract: one SEG-bit segment and one register per
// stage, valid/ready on both sides, empty stages fill even while later ones stall.
module pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iC,
    input  logic             iSub,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oSum,
    output logic             oCarryout,
    output logic             oOverflow
);

    localparam int SEG = WIDTH / STAGES;

    if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : gBadCfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    typedef struct packed {
        stageFlagsT       f;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] sum;
    } payloadT;

    for (genvar k = 0; k < STAGES; k++) begin : gStage
        payloadT        src;
        payloadT        nxt;
        payloadT        q;
        logic           load;
        logic           adv;
        logic [SEG-1:0] segSum;
        logic           segCo;
        logic           segCm;

        // Stage 0 sees the ports directly: subtraction folds into ~B plus inverted carry-in.
        if (k == 0) begin : gSrc
            assign src = '{
                f:   '{valid: iValid, carry: iC ^ iSub, cMsb: 1'b0},
                a:   iA,
                b:   (iSub == ALU_OP_SUB) ? ~iB : iB,
                sum: '0
            };
        end else begin : gSrc
            assign src = gStage[k-1].q;
        end

        pipe_adder_seg #(.SEG(SEG)) uSeg (
            .iA        (src.a[k*SEG +: SEG]),
            .iB        (src.b[k*SEG +: SEG]),
            .iC        (src.f.carry),
            .oSum      (segSum),
            .oCarryout (segCo),
            .oC_msb    (segCm)
        );

        always_comb begin
            nxt                    = src;
            nxt.sum[k*SEG +: SEG]  = segSum;
            nxt.f.carry            = segCo;
            nxt.f.cMsb             = segCm;
        end

        if (k == STAGES - 1) begin : gAdv
            assign adv = q.f.valid & iReady;
        end else begin : gAdv
            assign adv = q.f.valid & gStage[k+1].load;
        end

        assign load = src.f.valid & (~q.f.valid | adv);

        always_ff @(posedge iClk) begin
            if (iRst) begin
                q <= '0;
            end else if (load) begin
                q <= nxt;
            end else if (adv) begin
                q.f.valid <= 1'b0;
            end
        end
    end

    assign oReady    = ~gStage[0].q.f.valid | gStage[0].adv;
    assign oValid    = gStage[STAGES-1].q.f.valid;
    assign oSum      = gStage[STAGES-1].q.sum;
    assign oCarryout = gStage[STAGES-1].q.f.carry;
    assign oOverflow = gStage[STAGES-1].q.f.cMsb ^ gStage[STAGES-1].q.f.carry;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed cases on an 8-bit/2-stage unit,
// randomized handshake traffic on 16-bit/4-stage and 16-bit/1-stage units.
module tb_pipe_adder;

    typedef struct packed {
        logic [15:0] sum;
        logic        carry;
        logic        ovf;
    } resT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 8-bit, 2-stage unit for directed tests
    logic       dRst, dIValid, dOReady, dC, dSub, dOValid, dIReady, dCo, dOv;
    logic [7:0] dA, dB, dSum;

    pipe_adder #(.WIDTH(8), .STAGES(2)) uDut8 (
        .iClk(clk), .iRst(dRst), .iValid(dIValid), .oReady(dOReady),
        .iA(dA), .iB(dB), .iC(dC), .iSub(dSub),
        .oValid(dOValid), .iReady(dIReady), .oSum(dSum),
        .oCarryout(dCo), .oOverflow(dOv)
    );

    // 16-bit units sharing one random stimulus stream
    logic        rRst, rIValid, rIReady, rC, rSub;
    logic [15:0] rA, rB;
    logic        bOReady, bOValid, bCo, bOv;
    logic [15:0] bSum;
    logic        cOReady, cOValid, cCo, cOv;
    logic [15:0] cSum;

    pipe_adder #(.WIDTH(16), .STAGES(4)) uDut16x4 (
        .iClk(clk), .iRst(rRst), .iValid(rIValid), .oReady(bOReady),
        .iA(rA), .iB(rB), .iC(rC), .iSub(rSub),
        .oValid(bOValid), .iReady(rIReady), .oSum(bSum),
        .oCarryout(bCo), .oOverflow(bOv)
    );

    pipe_adder #(.WIDTH(16), .STAGES(1)) uDut16x1 (
        .iClk(clk), .iRst(rRst), .iValid(rIValid), .oReady(cOReady),
        .iA(rA), .iB(rB), .iC(rC), .iSub(rSub),
        .oValid(cOValid), .iReady(rIReady), .oSum(cSum),
        .oCarryout(cCo), .oOverflow(cOv)
    );

    // Reference: integer arithmetic on the operand values.
    function automatic resT model(input int w, input longint a, input longint b,
                                  input longint c, input bit sub);
        longint m, r, sa, sb, sr;
        resT    o;
        m  = longint'(1) << w;
        r  = sub ? (a - b - c) : (a + b + c);
        sa = (a >= m / 2) ? a - m : a;
        sb = (b >= m / 2) ? b - m : b;
        sr = sub ? (sa - sb - c) : (sa + sb + c);
        o.sum   = 16'(((r % m) + m) % m);
        o.carry = sub ? (a >= b + c) : (r >= m);
        o.ovf   = (sr < -(m / 2)) || (sr > (m / 2) - 1);
        return o;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic runOp(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic s, output resT got, output int lat);
        int waitCnt;
        @(posedge clk); #1;
        dIValid = 1'b1; dA = a; dB = b; dC = c; dSub = s;
        waitCnt = 0;
        @(negedge clk);
        while (!dOReady && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        @(posedge clk); #1;
        dIValid = 1'b0; dA = 8'($urandom); dB = 8'($urandom);
        lat = -1;
        got = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (dOValid) begin
                lat = i;
                got = '{sum: 16'(dSum), carry: dCo, ovf: dOv};
                break;
            end
        end
    endtask

    // Scoreboards for the randomized units
    resT qB[$];
    resT qC[$];
    int  accB = 0;
    int  accC = 0;
    bit  randOn = 1'b0;

    always @(negedge clk) begin : cmp
        resT e, g;
        if (rRst) begin
            qB.delete();
            qC.delete();
        end else if (randOn) begin
            if (bOValid && rIReady) begin
                if (qB.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd4_spurious: actual=%0h required=none", bSum);
                end else begin
                    e = qB.pop_front();
                    g = '{sum: bSum, carry: bCo, ovf: bOv};
                    check("rnd4_result", g, e);
                end
            end
            if (rIValid && bOReady) begin
                qB.push_back(model(16, rA, rB, rC, rSub));
                accB++;
            end
            check("rnd4_capacity", longint'(qB.size() <= 4), 1);

            if (cOValid && rIReady) begin
                if (qC.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rnd1_spurious: actual=%0h required=none", cSum);
                end else begin
                    e = qC.pop_front();
                    g = '{sum: cSum, carry: cCo, ovf: cOv};
                    check("rnd1_result", g, e);
                end
            end
            if (rIValid && cOReady) begin
                qC.push_back(model(16, rA, rB, rC, rSub));
                accC++;
            end
            check("rnd1_capacity", longint'(qC.size() <= 1), 1);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        resT        got;
        int         lat;
        int         nSent, nRecv, cyc;
        logic [7:0] held;
        bit         haveHeld;
        resT        bpExp [5];
        int         emitCyc [5];

        dRst = 1'b1; dIValid = 1'b0; dIReady = 1'b1; dA = '0; dB = '0; dC = 1'b0; dSub = 1'b0;
        rRst = 1'b1; rIValid = 1'b0; rIReady = 1'b0; rA = '0; rB = '0; rC = 1'b0; rSub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        dRst = 1'b0;
        rRst = 1'b0;

        @(negedge clk);
        check("rst_oValid", dOValid, 0);
        check("rst_oSum", dSum, 0);
        check("rst_oCarryout", dCo, 0);
        check("rst_oOverflow", dOv, 0);
        check("rst_oReady", dOReady, 1);
        check("rst_oValid16x4", bOValid, 0);
        check("rst_oValid16x1", cOValid, 0);

        // Pin the reference model to hand-computed values.
        check("model_addwrap", model(8, 'hFF, 'h01, 0, 0), resT'{sum: 16'h00, carry: 1'b1, ovf: 1'b0});
        check("model_addovf", model(8, 'h7F, 'h01, 0, 0), resT'{sum: 16'h80, carry: 1'b0, ovf: 1'b1});
        check("model_subovf", model(8, 'h80, 'h01, 0, 1), resT'{sum: 16'h7F, carry: 1'b1, ovf: 1'b1});
        check("model_subborrow", model(8, 'h10, 'h20, 1, 1), resT'{sum: 16'hEF, carry: 1'b0, ovf: 1'b0});
        check("model_sub16", model(16, 'h0000, 'h0001, 0, 1), resT'{sum: 16'hFFFF, carry: 1'b0, ovf: 1'b0});

        // Directed cases on the 8-bit unit
        runOp(8'hFF, 8'h01, 1'b0, 1'b0, got, lat);
        check("addwrap_lat", lat, 2);
        check("addwrap_res", got, resT'{sum: 16'h00, carry: 1'b1, ovf: 1'b0});
        runOp(8'h7F, 8'h01, 1'b0, 1'b0, got, lat);
        check("addovf_res", got, resT'{sum: 16'h80, carry: 1'b0, ovf: 1'b1});
        runOp(8'h80, 8'h01, 1'b0, 1'b1, got, lat);
        check("subovf_res", got, resT'{sum: 16'h7F, carry: 1'b1, ovf: 1'b1});
        runOp(8'h10, 8'h20, 1'b0, 1'b1, got, lat);
        check("subborrow_res", got, resT'{sum: 16'hF0, carry: 1'b0, ovf: 1'b0});
        runOp(8'h10, 8'h20, 1'b1, 1'b1, got, lat);
        check("subborrowin_res", got, resT'{sum: 16'hEF, carry: 1'b0, ovf: 1'b0});
        check("subborrowin_lat", lat, 2);

        // Backpressure: only two ops fit while the output is stalled
        for (int i = 0; i < 5; i++) begin
            bpExp[i] = model(8, 'h10 + i, 3 * i, 0, 0);
            emitCyc[i] = 0;
        end
        nSent = 0; nRecv = 0; haveHeld = 1'b0; held = '0;
        @(posedge clk); #1;
        dIReady = 1'b0;
        dIValid = 1'b1; dA = 8'h10; dB = 8'h00; dC = 1'b0; dSub = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dIValid && dOReady) nSent++;
            if (dOValid) begin
                if (!haveHeld) begin
                    held = dSum;
                    haveHeld = 1'b1;
                end else begin
                    check("bp_hold", dSum, held);
                end
            end
            @(posedge clk); #1;
            dA = 8'(8'h10 + nSent);
            dB = 8'(3 * nSent);
        end
        check("bp_accepted", nSent, 2);
        @(negedge clk);
        check("bp_oReady", dOReady, 0);
        check("bp_oValid", dOValid, 1);
        @(posedge clk); #1;
        dIReady = 1'b1;
        cyc = 0;
        while (nRecv < 5 && cyc < 30) begin
            @(negedge clk);
            if (dOValid && dIReady) begin
                check("bp_order", dSum, bpExp[nRecv].sum);
                emitCyc[nRecv] = cyc;
                nRecv++;
            end
            if (dIValid && dOReady) nSent++;
            @(posedge clk); #1;
            dIValid = (nSent < 5);
            dA = 8'(8'h10 + nSent);
            dB = 8'(3 * nSent);
            cyc++;
        end
        dIValid = 1'b0;
        check("bp_count", nRecv, 5);
        check("bp_backtoback", emitCyc[1] - emitCyc[0], 1);

        // Reset with two ops in flight
        repeat (3) @(posedge clk);
        #1;
        dIReady = 1'b0;
        dIValid = 1'b1; dA = 8'h55; dB = 8'h11;
        @(negedge clk);
        @(posedge clk); #1;
        dA = 8'h66;
        @(negedge clk);
        @(posedge clk); #1;
        dIValid = 1'b0;
        dRst = 1'b1;
        @(posedge clk); #1;
        dRst = 1'b0;
        dIReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstmid_noValid", dOValid, 0);
        end
        check("rstmid_oReady", dOReady, 1);
        runOp(8'h01, 8'h02, 1'b1, 1'b0, got, lat);
        check("rstmid_lat", lat, 2);
        check("rstmid_res", got, resT'{sum: 16'h04, carry: 1'b0, ovf: 1'b0});

        // Randomized traffic on the 16-bit units
        randOn = 1'b1;
        cyc = 0;
        while ((accB < 10000 || accC < 10000) && cyc < 40000) begin
            @(posedge clk); #1;
            rIValid = ($urandom_range(0, 3) != 0);
            rIReady = ($urandom_range(0, 3) != 0);
            rA   = 16'($urandom);
            rB   = 16'($urandom);
            rC   = 1'($urandom_range(0, 1));
            rSub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: rA = 16'hFFFF;
                1: rA = 16'h8000;
                2: rB = 16'h7FFF;
                3: rB = 16'hFFFF;
                default: ;
            endcase
            cyc++;
        end
        @(posedge clk); #1;
        rIValid = 1'b0;
        rIReady = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        check("drain16x4", qB.size(), 0);
        check("drain16x1", qC.size(), 0);
        check("ops16x4", longint'(accB >= 10000), 1);
        check("ops16x1", longint'(accC >= 10000), 1);
        randOn = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
